// File: rtl/load_store_unit_if.sv
// Memory-side bus between the load/store unit (master) and a single-word memory port (slave).
interface load_store_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one outstanding word-bus access, lane steering and load extension.
// Optional bus timeout enabled by defining LSU_TIMEOUT_EN.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [31:0]       ALUResult,
  input  logic [31:0]       WriteData,
  output logic [31:0]       ReadData,
  output logic              stall,
  output logic              fault,
  output logic [1:0]        fault_code,
  load_store_unit_if.master bus
);

  if (TIMEOUT == 0) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;
  logic [1:0]  code_q, code_d;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
`endif

  logic        illegal, misaligned;
  logic [3:0]  be_sel;
  logic [31:0] wdata_sel;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  // Request decode: funct3[1:0] encodes the access size for both loads and stores.
  always_comb begin
    if (mem_write) illegal = funct3[2] | (funct3[1:0] == 2'b11);
    else           illegal = (funct3[1:0] == 2'b11) | (funct3[2:1] == 2'b11);
    misaligned = ((funct3[1:0] == 2'b01) & ALUResult[0]) |
                 ((funct3[1:0] == 2'b10) & (ALUResult[1:0] != 2'b00));
    unique case (funct3[1:0])
      2'b00: begin
        be_sel    = 4'b0001 << ALUResult[1:0];
        wdata_sel = {4{WriteData[7:0]}};
      end
      2'b01: begin
        be_sel    = ALUResult[1] ? 4'b1100 : 4'b0011;
        wdata_sel = {2{WriteData[15:0]}};
      end
      default: begin
        be_sel    = 4'b1111;
        wdata_sel = WriteData;
      end
    endcase
  end

  always_comb begin
    unique case (lane_q)
      2'd0: ld_byte = bus.bus_rdata[7:0];
      2'd1: ld_byte = bus.bus_rdata[15:8];
      2'd2: ld_byte = bus.bus_rdata[23:16];
      2'd3: ld_byte = bus.bus_rdata[31:24];
    endcase
    ld_half = lane_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
    case (f3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'h0, ld_byte};
      3'b101:  ld_ext = {16'h0, ld_half};
      default: ld_ext = bus.bus_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    lane_d  = lane_q;
    rdata_d = 32'h0;
    fault_d = 1'b0;
    code_d  = 2'b00;
    stall   = 1'b0;
`ifdef LSU_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (illegal) begin
            fault_d = 1'b1;
            code_d  = 2'b10;
          end else if (misaligned) begin
            fault_d = 1'b1;
            code_d  = 2'b01;
          end else begin
            stall   = 1'b1;
            state_d = StBusy;
            req_d   = 1'b1;
            we_d    = mem_write;
            addr_d  = {ALUResult[31:2], 2'b00};
            be_d    = be_sel;
            wdata_d = wdata_sel;
            f3_d    = funct3;
            lane_d  = ALUResult[1:0];
`ifdef LSU_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      StBusy: begin
        stall = 1'b1;
        // An ack in the terminal-count cycle still completes normally.
        if (bus.bus_ack) begin
          req_d   = 1'b0;
          rdata_d = we_q ? 32'h0 : ld_ext;
          state_d = StDone;
`ifdef LSU_TIMEOUT_EN
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          req_d   = 1'b0;
          fault_d = 1'b1;
          code_d  = 2'b11;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (!reset) stall = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      be_q    <= 4'h0;
      wdata_q <= 32'h0;
      f3_q    <= 3'b000;
      lane_q  <= 2'b00;
      rdata_q <= 32'h0;
      fault_q <= 1'b0;
      code_q  <= 2'b00;
`ifdef LSU_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      lane_q  <= lane_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
      code_q  <= code_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign ReadData      = rdata_q;
  assign fault         = fault_q;
  assign fault_code    = code_q;
  assign bus.bus_req   = req_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_be    = be_q;
  assign bus.bus_wdata = wdata_q;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter: TIMEOUT, 16, max BUSY cycles awaiting bus_ack (used only with LSU_TIMEOUT_EN).
REQ-002 SHALL have ports, one clock; reset is synchronous and active-low:
 clk  in  1  rising-edge clock
 reset  in  1  synchronous, active-low reset
 req_valid  in  1  datapath presents a memory instruction this cycle
 mem_write  in  1  1=store, 0=load
 funct3  in  3  RV32I size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
 ALUResult  in  32  byte address from datapath
 WriteData  in  32  store data (rs2)
 ReadData  out  32  extended load result to datapath
 stall  out  1  datapath must hold PC/regs
 fault  out  1  one-cycle fault pulse
 fault_code  out  2  01 misaligned, 10 illegal funct3, 11 timeout
 bus_req  out  1  bus request, held until ack
 bus_we  out  1  bus write enable
 bus_addr  out  32  word address, bits[1:0]=00
 bus_be  out  4  byte-lane enables
 bus_wdata  out  32  lane-replicated store data
 bus_ack  in  1  bus completion, one cycle
 bus_rdata  in  32  read word, valid with bus_ack

Function
REQ-003 SHALL implement FSM IDLE, BUSY, DONE; single outstanding access.
REQ-004 IDLE, req_valid=1, legal and aligned: stall=1 combinationally; latch address, data, funct3, mem_write; next state BUSY.
REQ-005 BUSY: bus_req=1 and all bus_* outputs registered, constant until exit; stall=1.
REQ-006 BUSY with bus_ack=1: capture extended load data (stores: ReadData=0); next DONE.
REQ-007 DONE: stall=0, ReadData valid this cycle only; next IDLE unconditionally (req_valid in DONE ignored).
REQ-008 Latency: ack in first BUSY cycle gives stall high exactly 2 cycles, DONE in cycle 3.
REQ-009 Alignment: h/hu/sh need addr[0]=0; w/sw need addr[1:0]=00; b always aligned.
REQ-010 Misaligned or illegal funct3 (loads 011/110/111, stores other than 000/001/010) in IDLE: no bus access, stall=0, fault=1 one cycle with code 01/10; illegal takes priority; state stays IDLE.
REQ-011 bus_be: byte 0001<<addr[1:0]; half 0011 (addr[1]=0) or 1100; word 1111; same lanes for loads.
REQ-012 bus_wdata: sb replicates WriteData[7:0] x4; sh replicates [15:0] x2; sw passes [31:0].
REQ-013 Loads select lane by addr[1:0]; b/h sign-extend, bu/hu zero-extend to 32 bits.
REQ-014 bus_ack outside BUSY SHALL be ignored.

Reset
REQ-015 reset=0 at a clk edge: state IDLE; bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, ReadData=0, fault=0, fault_code=00, timeout counter=0.
REQ-016 Reset while BUSY SHALL drop bus_req the following cycle, discarding the access with no fault.
REQ-017 stall SHALL be 0 while reset=0.

Configuration
REQ-018 Macro LSU_TIMEOUT_EN defined: counter increments each BUSY cycle without ack; reaching TIMEOUT drops bus_req, pulses fault with code 11, ReadData=0, goes to DONE.
REQ-019 bus_ack in the terminal-count cycle SHALL win: normal completion, no fault.
REQ-020 Macro undefined: no counter, BUSY waits indefinitely, code 11 never produced.

Verification
REQ-021 lw addr 0x100, bus_rdata=0xDEADBEEF, ack in first BUSY cycle -> bus_addr=0x100, be=1111, stall 2 cycles, ReadData=0xDEADBEEF in DONE.
REQ-022 lb addr 0x103, rdata=0x80112233 -> be=1000, ReadData=0xFFFFFF80; lbu same -> 0x00000080.
REQ-023 sh addr 0x202, WriteData=0x0000ABCD, ack after 3 cycles -> bus_addr=0x200, be=1100, wdata=0xABCDABCD, we=1, stall 4 cycles.
REQ-024 lw addr 0x101 -> no bus_req, fault=1 one cycle, code 01, stall=0; funct3=011 load -> code 10.
REQ-025 LSU_TIMEOUT_EN, TIMEOUT=16, no ack -> bus_req drops after 16 BUSY cycles, fault code 11; repeat with ack on cycle 16 -> no fault.
REQ-026 reset=0 in second BUSY cycle -> next cycle bus_req=0, IDLE, stall=0, no fault; later lw completes normally.
